render_state: RTL and testbench

RENDER_STATE -- requirements
Module: render_state

---
 rtl/render_state_pkg.sv | 43 ++++
 rtl/render_state_fixed_mul.sv | 13 +
 rtl/render_state.sv | 184 ++++++++++++++++++
 tb/tb_render_state.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/render_state_pkg.sv
// Shared Q16.16 types, FSM encoding and fixed-point multiply for render_state.
// Optional focus scaling of W is enabled by RENDER_STATE_FOCUS_SCALE_EN.
package render_state_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] Fixed;

    typedef struct packed {
        Fixed x;
        Fixed y;
        Fixed z;
    } Fixed3;

    typedef struct packed {
        Fixed3 eye;
        Fixed3 w;
        Fixed3 u;
        Fixed3 v;
        Fixed  focus;
    } RenderState;

    typedef enum logic [3:0] {
        IDLE,
        DIFF,
        MUL0,
        MUL1,
        MUL2,
        MUL3,
        SCL0,
        SCL1,
        SCL2,
        COMMIT
    } state_e;

    // Full 64-bit product, arithmetic shift, keep the low 32 bits (wraps).
    function automatic Fixed fmul(input Fixed a, input Fixed b);
        logic signed [63:0] p;
        p = a * b;
        return Fixed'(p >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/render_state_fixed_mul.sv
// Combinational 32x32 signed Q16.16 multiplier shared by the render_state FSM.
// Part of render_state (feature macro RENDER_STATE_FOCUS_SCALE_EN).
module fixed_mul
    import render_state_pkg::*;
(
    input  Fixed a_i,
    input  Fixed b_i,
    output Fixed p_o
);

    assign p_o = fmul(a_i, b_i);

endmodule

// File: rtl/render_state.sv
// Camera basis builder: W = look - pos, U = (-Wz, 0, Wx), V = cross(U, W).
// Define RENDER_STATE_FOCUS_SCALE_EN to scale W by the focus distance.
module render_state
    import render_state_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       strobe,
    input  Fixed3      pos,
    input  Fixed3      look,
    input  Fixed       focus_dist,
    output RenderState rs,
    output logic       valid
);

    state_e     state_q, state_d;
    Fixed3      pos_q, pos_d;
    Fixed3      look_q, look_d;
    Fixed       focus_q, focus_d;
    Fixed3      w_q, w_d;
    Fixed3      u_q, u_d;
    Fixed       p0_q, p0_d;
    Fixed       p1_q, p1_d;
    Fixed       p2_q, p2_d;
    Fixed       p3_q, p3_d;
    RenderState rs_q, rs_d;
    logic       valid_q, valid_d;
    Fixed3      w_new;
    Fixed       mul_a, mul_b, mul_p;
`ifdef RENDER_STATE_FOCUS_SCALE_EN
    Fixed3      ws_q, ws_d;
`endif

    fixed_mul u_mul (
        .a_i(mul_a),
        .b_i(mul_b),
        .p_o(mul_p)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pos_q   <= '0;
            look_q  <= '0;
            focus_q <= '0;
            w_q     <= '0;
            u_q     <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            rs_q    <= '0;
            valid_q <= 1'b0;
`ifdef RENDER_STATE_FOCUS_SCALE_EN
            ws_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            look_q  <= look_d;
            focus_q <= focus_d;
            w_q     <= w_d;
            u_q     <= u_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            rs_q    <= rs_d;
            valid_q <= valid_d;
`ifdef RENDER_STATE_FOCUS_SCALE_EN
            ws_q    <= ws_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        look_d  = look_q;
        focus_d = focus_q;
        w_d     = w_q;
        u_d     = u_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        rs_d    = rs_q;
        valid_d = valid_q;
        mul_a   = '0;
        mul_b   = '0;
`ifdef RENDER_STATE_FOCUS_SCALE_EN
        ws_d    = ws_q;
`endif
        w_new.x = look_q.x - pos_q.x;
        w_new.y = look_q.y - pos_q.y;
        w_new.z = look_q.z - pos_q.z;

        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    pos_d   = pos;
                    look_d  = look;
                    focus_d = focus_dist;
                    state_d = DIFF;
                end
            end
            DIFF: begin
                w_d     = w_new;
                u_d.x   = -w_new.z;
                u_d.y   = '0;
                u_d.z   = w_new.x;
                state_d = MUL0;
            end
            MUL0: begin
                mul_a   = w_q.x;
                mul_b   = w_q.y;
                p0_d    = mul_p;
                state_d = MUL1;
            end
            MUL1: begin
                mul_a   = w_q.x;
                mul_b   = w_q.x;
                p1_d    = mul_p;
                state_d = MUL2;
            end
            MUL2: begin
                mul_a   = w_q.z;
                mul_b   = w_q.z;
                p2_d    = mul_p;
                state_d = MUL3;
            end
            MUL3: begin
                mul_a   = w_q.z;
                mul_b   = w_q.y;
                p3_d    = mul_p;
`ifdef RENDER_STATE_FOCUS_SCALE_EN
                state_d = SCL0;
`else
                state_d = COMMIT;
`endif
            end
`ifdef RENDER_STATE_FOCUS_SCALE_EN
            SCL0: begin
                mul_a   = w_q.x;
                mul_b   = focus_q;
                ws_d.x  = mul_p;
                state_d = SCL1;
            end
            SCL1: begin
                mul_a   = w_q.y;
                mul_b   = focus_q;
                ws_d.y  = mul_p;
                state_d = SCL2;
            end
            SCL2: begin
                mul_a   = w_q.z;
                mul_b   = focus_q;
                ws_d.z  = mul_p;
                state_d = COMMIT;
            end
`endif
            COMMIT: begin
                rs_d.eye   = pos_q;
                rs_d.focus = focus_q;
`ifdef RENDER_STATE_FOCUS_SCALE_EN
                rs_d.w     = ws_q;
`else
                rs_d.w     = w_q;
`endif
                rs_d.u     = u_q;
                rs_d.v.x   = -p0_q;
                rs_d.v.y   = p1_q + p2_q;
                rs_d.v.z   = -p3_q;
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rs    = rs_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_render_state.sv
// Directed self-checking bench for render_state with hand-computed vectors.
// Latency expectations follow RENDER_STATE_FOCUS_SCALE_EN when defined.
module tb_render_state;
    import render_state_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       strobe = 1'b0;
    Fixed3      pos = '0;
    Fixed3      look = '0;
    Fixed       focus_dist = '0;
    RenderState rs;
    logic       valid;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef RENDER_STATE_FOCUS_SCALE_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 6;
`endif

    localparam Fixed ONE = 32'h0001_0000;

    always #5 clk = ~clk;

    render_state dut (
        .clk(clk),
        .resetn(resetn),
        .strobe(strobe),
        .pos(pos),
        .look(look),
        .focus_dist(focus_dist),
        .rs(rs),
        .valid(valid)
    );

    function automatic Fixed3 f3(input Fixed x, input Fixed y, input Fixed z);
        Fixed3 r;
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    function automatic RenderState mk(input Fixed3 e, input Fixed3 w,
                                      input Fixed3 u, input Fixed3 v,
                                      input Fixed f);
        RenderState r;
        r.eye   = e;
        r.w     = w;
        r.u     = u;
        r.v     = v;
        r.focus = f;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rs(input string tag, input RenderState exp);
        n_assert++;
        assert (rs === exp) else begin
            n_fail++;
            $error("FAIL %s: rs observed %h expected %h", tag, rs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic exp);
        n_assert++;
        assert (valid === exp) else begin
            n_fail++;
            $error("FAIL %s: valid observed %b expected %b", tag, valid, exp);
        end
    endtask

    // Pulse strobe, confirm rs holds one edge before commit, then check.
    task automatic go(input string tag, input Fixed3 p, input Fixed3 l,
                      input Fixed f, input RenderState prev,
                      input logic prev_v, input RenderState exp);
        pos        = p;
        look       = l;
        focus_dist = f;
        strobe     = 1'b1;
        tick();
        strobe     = 1'b0;
        repeat (LAT - 1) tick();
        chk_rs({tag, "_hold"}, prev);
        chk_v({tag, "_hold_v"}, prev_v);
        tick();
        chk_rs(tag, exp);
        chk_v({tag, "_v"}, 1'b1);
    endtask

    RenderState e2, e3, e4, e5, zero;

    initial begin
        zero = '0;
        e2 = mk(f3(0, 0, 0), f3(0, 0, 32'hFFFF_0000),
                f3(ONE, 0, 0), f3(0, ONE, 0), ONE);
        e3 = mk(f3(32'h1_0000, 32'h2_0000, 32'h3_0000),
                f3(32'h2_0000, 0, 0), f3(0, 0, 32'h2_0000),
                f3(0, 32'h4_0000, 0), ONE);
        e4 = mk(f3(0, 0, 0),
                f3(32'h1_8000, 32'h0_8000, 32'hFFFF_8000),
                f3(32'h0_8000, 0, 32'h1_8000),
                f3(32'hFFFF_4000, 32'h2_8000, 32'h0_4000), ONE);
        e5 = mk(f3(32'h8000_0000, 0, 0),
                f3(32'hFFFF_FFFF, 32'h0000_8000, 0),
                f3(0, 0, 32'hFFFF_FFFF),
                f3(32'h0000_0001, 0, 0), ONE);

        #12;
        chk_rs("reset_rs", zero);
        chk_v("reset_valid", 1'b0);
        resetn = 1'b1;
        repeat (20) tick();
        chk_rs("idle20_rs", zero);
        chk_v("idle20_valid", 1'b0);

        go("basic", f3(0, 0, 0), f3(0, 0, 32'hFFFF_0000), ONE,
           zero, 1'b0, e2);
        go("offset", e3.eye, f3(32'h3_0000, 32'h2_0000, 32'h3_0000), ONE,
           e2, 1'b1, e3);
        go("frac", f3(0, 0, 0), e4.w, ONE, e3, 1'b1, e4);
        go("wrap_trunc", e5.eye, f3(32'h7FFF_FFFF, 32'h0000_8000, 0), ONE,
           e4, 1'b1, e5);

        // Strobe held high; inputs change after the first latch.
        pos        = f3(0, 0, 0);
        look       = f3(0, 0, 32'hFFFF_0000);
        focus_dist = ONE;
        strobe     = 1'b1;
        tick();
        pos  = e3.eye;
        look = f3(32'h3_0000, 32'h2_0000, 32'h3_0000);
        repeat (LAT - 1) tick();
        chk_rs("held_pre", e5);
        tick();
        chk_rs("held_first", e2);
        repeat (LAT) tick();
        chk_rs("held_between", e2);
        tick();
        chk_rs("held_second", e3);
        strobe = 1'b0;
        repeat (3) tick();
        chk_rs("held_idle", e3);

        // Reset pulse while in MUL2.
        pos        = f3(0, 0, 0);
        look       = e4.w;
        focus_dist = ONE;
        strobe     = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (3) tick();
        resetn = 1'b0;
        #2;
        chk_rs("abort_rs", zero);
        chk_v("abort_valid", 1'b0);
        resetn = 1'b1;
        repeat (10) tick();
        chk_rs("abort_after_rs", zero);
        chk_v("abort_after_valid", 1'b0);
        go("post_reset", f3(0, 0, 0), f3(0, 0, 32'hFFFF_0000), ONE,
           zero, 1'b0, e2);

`ifdef RENDER_STATE_FOCUS_SCALE_EN
        go("scale2", f3(0, 0, 0), f3(0, 0, 32'hFFFF_0000), 32'h2_0000,
           e2, 1'b1,
           mk(f3(0, 0, 0), f3(0, 0, 32'hFFFE_0000),
              f3(ONE, 0, 0), f3(0, ONE, 0), 32'h2_0000));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
